// File: rtl/exu_csrfile.sv
// Machine-mode CSR register file for the cirno9 core.
// Serves the execute-stage CSR access port (combinational read, write at the
// clock edge), holds trap state, the 64-bit cycle/instret counters and the
// interrupt enable/pending bits, and drives mtvec/mepc/irq_req to control.
// Event priority for shared fields: trap > mret > CSR write. A trap flushes
// the whole CSR write; counter increments continue under trap/mret.
module exu_csrfile #(
   parameter logic [31:0] HART_ID   = 32'h0,
   parameter logic [31:0] MISA_VAL  = 32'h4000_1104,
   parameter logic [31:0] MTVEC_RST = 32'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        csr_ren,
   input  logic        csr_wen,
   input  logic [11:0] csr_idx,
   input  logic [31:0] csr_wdat,
   output logic [31:0] csr_rdat,
   output logic        csr_ill,
   input  logic        instret,
   input  logic        trap_val,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_tval,
   input  logic        mret_val,
   input  logic        ext_irq,
   input  logic        tmr_irq,
   output logic [31:0] mtvec_o,
   output logic [31:0] mepc_o,
   output logic        irq_req
);

   localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
   localparam logic [11:0] ADDR_MISA      = 12'h301;
   localparam logic [11:0] ADDR_MIE       = 12'h304;
   localparam logic [11:0] ADDR_MTVEC     = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
   localparam logic [11:0] ADDR_MEPC      = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
   localparam logic [11:0] ADDR_MTVAL     = 12'h343;
   localparam logic [11:0] ADDR_MIP       = 12'h344;
   localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
   localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
   localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
   localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
   localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

   // Only MSIE/MTIE/MEIE exist in mie.
   localparam logic [31:0] MIE_MASK = 32'h0000_0888;

   logic        r_mstatus_mie;
   logic        r_mstatus_mpie;
   logic [31:0] r_mie;
   logic [31:0] r_mtvec;
   logic [31:0] r_mscratch;
   logic [31:0] r_mepc;
   logic [31:0] r_mcause;
   logic [31:0] r_mtval;
   logic        r_msip;
   logic [63:0] r_mcycle;
   logic [63:0] r_minstret;

   logic [31:0] w_mstatus;
   logic [31:0] w_mip;
   logic [31:0] w_sel;
   logic        w_impl;
   logic        w_wr;
   logic        w_wr_mstatus;
   logic        w_wr_mie;
   logic        w_wr_mtvec;
   logic        w_wr_mscratch;
   logic        w_wr_mepc;
   logic        w_wr_mcause;
   logic        w_wr_mtval;
   logic        w_wr_mip;
   logic        w_wr_mcycle_lo;
   logic        w_wr_mcycle_hi;
   logic        w_wr_minstret_lo;
   logic        w_wr_minstret_hi;

   // MPP is hard-wired to machine mode; everything but MIE/MPIE reads zero.
   assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
   // MTIP/MEIP are live input levels; only MSIP is software state.
   assign w_mip     = {20'b0, ext_irq, 3'b0, tmr_irq, 3'b0, r_msip, 3'b0};

   // Read mux and implemented-index decode, combinational from csr_idx.
   always_comb begin
      w_impl = 1'b1;
      w_sel  = 32'h0;
      case (csr_idx)
         ADDR_MSTATUS:   w_sel = w_mstatus;
         ADDR_MISA:      w_sel = MISA_VAL;
         ADDR_MIE:       w_sel = r_mie;
         ADDR_MTVEC:     w_sel = r_mtvec;
         ADDR_MSCRATCH:  w_sel = r_mscratch;
         ADDR_MEPC:      w_sel = r_mepc;
         ADDR_MCAUSE:    w_sel = r_mcause;
         ADDR_MTVAL:     w_sel = r_mtval;
         ADDR_MIP:       w_sel = w_mip;
         ADDR_MCYCLE:    w_sel = r_mcycle[31:0];
         ADDR_MCYCLEH:   w_sel = r_mcycle[63:32];
         ADDR_MINSTRET:  w_sel = r_minstret[31:0];
         ADDR_MINSTRETH: w_sel = r_minstret[63:32];
         ADDR_MVENDORID: w_sel = 32'h0;
         ADDR_MARCHID:   w_sel = 32'h0;
         ADDR_MIMPID:    w_sel = 32'h0;
         ADDR_MHARTID:   w_sel = HART_ID;
         default:        w_impl = 1'b0;
      endcase
   end

   assign csr_rdat = csr_ren ? w_sel : 32'h0;
   assign csr_ill  = (csr_ren | csr_wen) & ~w_impl;

   // A write lands only on implemented, writable indices and never under a
   // trap. The read-only space (idx[11:10]==2'b11) drops writes silently.
   assign w_wr             = csr_wen & ~trap_val & w_impl & (csr_idx[11:10] != 2'b11);
   assign w_wr_mstatus     = w_wr & (csr_idx == ADDR_MSTATUS);
   assign w_wr_mie         = w_wr & (csr_idx == ADDR_MIE);
   assign w_wr_mtvec       = w_wr & (csr_idx == ADDR_MTVEC);
   assign w_wr_mscratch    = w_wr & (csr_idx == ADDR_MSCRATCH);
   assign w_wr_mepc        = w_wr & (csr_idx == ADDR_MEPC);
   assign w_wr_mcause      = w_wr & (csr_idx == ADDR_MCAUSE);
   assign w_wr_mtval       = w_wr & (csr_idx == ADDR_MTVAL);
   assign w_wr_mip         = w_wr & (csr_idx == ADDR_MIP);
   assign w_wr_mcycle_lo   = w_wr & (csr_idx == ADDR_MCYCLE);
   assign w_wr_mcycle_hi   = w_wr & (csr_idx == ADDR_MCYCLEH);
   assign w_wr_minstret_lo = w_wr & (csr_idx == ADDR_MINSTRET);
   assign w_wr_minstret_hi = w_wr & (csr_idx == ADDR_MINSTRETH);

   // mstatus MIE/MPIE: trap stacks MIE, mret unstacks it, else CSR write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
      end else if (trap_val) begin
         r_mstatus_mpie <= r_mstatus_mie;
         r_mstatus_mie  <= 1'b0;
      end else if (mret_val) begin
         r_mstatus_mie  <= r_mstatus_mpie;
         r_mstatus_mpie <= 1'b1;
      end else if (w_wr_mstatus) begin
         r_mstatus_mie  <= csr_wdat[3];
         r_mstatus_mpie <= csr_wdat[7];
      end
   end

   // Trap state: a trap captures pc/cause/tval, otherwise CSR writes apply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mepc   <= 32'h0;
         r_mcause <= 32'h0;
         r_mtval  <= 32'h0;
      end else if (trap_val) begin
         r_mepc   <= trap_pc & 32'hFFFF_FFFE;
         r_mcause <= trap_cause;
         r_mtval  <= trap_tval;
      end else begin
         if (w_wr_mepc)   r_mepc   <= csr_wdat & 32'hFFFF_FFFE;
         if (w_wr_mcause) r_mcause <= csr_wdat;
         if (w_wr_mtval)  r_mtval  <= csr_wdat;
      end
   end

   // Plain software-written registers: mie, mtvec, mscratch, mip.MSIP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mie      <= 32'h0;
         r_mtvec    <= MTVEC_RST;
         r_mscratch <= 32'h0;
         r_msip     <= 1'b0;
      end else begin
         if (w_wr_mie)      r_mie      <= csr_wdat & MIE_MASK;
         if (w_wr_mtvec)    r_mtvec    <= csr_wdat & 32'hFFFF_FFFC;
         if (w_wr_mscratch) r_mscratch <= csr_wdat;
         if (w_wr_mip)      r_msip     <= csr_wdat[3];
      end
   end

   // mcycle: free-running; a write to either half freezes the whole counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcycle <= 64'h0;
      end else if (w_wr_mcycle_lo | w_wr_mcycle_hi) begin
         if (w_wr_mcycle_lo) r_mcycle[31:0]  <= csr_wdat;
         if (w_wr_mcycle_hi) r_mcycle[63:32] <= csr_wdat;
      end else begin
         r_mcycle <= r_mcycle + 64'd1;
      end
   end

   // minstret: counts retirements; a write to either half wins that cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_minstret <= 64'h0;
      end else if (w_wr_minstret_lo | w_wr_minstret_hi) begin
         if (w_wr_minstret_lo) r_minstret[31:0]  <= csr_wdat;
         if (w_wr_minstret_hi) r_minstret[63:32] <= csr_wdat;
      end else if (instret) begin
         r_minstret <= r_minstret + 64'd1;
      end
   end

   assign mtvec_o = r_mtvec;
   assign mepc_o  = r_mepc;
   assign irq_req = r_mstatus_mie & (|(r_mie & w_mip));

endmodule

// File: tb/tb_exu_csrfile.sv
// Testbench for exu_csrfile: constant-read vector table, hand-written
// sequences for trap/mret/counter/reset corner cases, and randomized CSR
// traffic compared every cycle against a CSR-level reference model.
module tb_exu_csrfile;

   logic        clk;
   logic        rst_n;
   logic        csr_ren;
   logic        csr_wen;
   logic [11:0] csr_idx;
   logic [31:0] csr_wdat;
   logic [31:0] csr_rdat;
   logic        csr_ill;
   logic        instret;
   logic        trap_val;
   logic [31:0] trap_cause;
   logic [31:0] trap_pc;
   logic [31:0] trap_tval;
   logic        mret_val;
   logic        ext_irq;
   logic        tmr_irq;
   logic [31:0] mtvec_o;
   logic [31:0] mepc_o;
   logic        irq_req;

   int n_cmp = 0;
   int n_err = 0;

   exu_csrfile dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .csr_ren    (csr_ren),
      .csr_wen    (csr_wen),
      .csr_idx    (csr_idx),
      .csr_wdat   (csr_wdat),
      .csr_rdat   (csr_rdat),
      .csr_ill    (csr_ill),
      .instret    (instret),
      .trap_val   (trap_val),
      .trap_cause (trap_cause),
      .trap_pc    (trap_pc),
      .trap_tval  (trap_tval),
      .mret_val   (mret_val),
      .ext_irq    (ext_irq),
      .tmr_irq    (tmr_irq),
      .mtvec_o    (mtvec_o),
      .mepc_o     (mepc_o),
      .irq_req    (irq_req)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Plain CSRs live in an address-keyed map; writes store wdat & mask.
   logic [31:0] m_reg [int];
   logic [63:0] m_cyc;
   logic [63:0] m_ins;

   function automatic logic [31:0] wmask(input int a);
      case (a)
         'h300:               return 32'h0000_0088;
         'h304:               return 32'h0000_0888;
         'h305:               return 32'hFFFF_FFFC;
         'h340, 'h342, 'h343: return 32'hFFFF_FFFF;
         'h341:               return 32'hFFFF_FFFE;
         'h344:               return 32'h0000_0008;
         default:             return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] mdl_mip();
      return m_reg['h344] | (32'(tmr_irq) << 7) | (32'(ext_irq) << 11);
   endfunction

   function automatic void mdl_read(input logic [11:0] idx, output logic [31:0] val,
                                    output logic impl);
      impl = 1'b1;
      val  = 32'h0;
      case (int'(idx))
         'h300: val = m_reg['h300] | 32'h0000_1800;
         'h301: val = 32'h4000_1104;
         'h304, 'h305, 'h340, 'h341, 'h342, 'h343: val = m_reg[int'(idx)];
         'h344: val = mdl_mip();
         'hB00: val = m_cyc[31:0];
         'hB80: val = m_cyc[63:32];
         'hB02: val = m_ins[31:0];
         'hB82: val = m_ins[63:32];
         'hF11, 'hF12, 'hF13, 'hF14: val = 32'h0;
         default: impl = 1'b0;
      endcase
   endfunction

   function automatic logic mdl_irq();
      return m_reg['h300][3] & (|(m_reg['h304] & mdl_mip()));
   endfunction

   task automatic model_reset();
      m_reg['h300] = 32'h0;
      m_reg['h304] = 32'h0;
      m_reg['h305] = 32'h0;
      m_reg['h340] = 32'h0;
      m_reg['h341] = 32'h0;
      m_reg['h342] = 32'h0;
      m_reg['h343] = 32'h0;
      m_reg['h344] = 32'h0;
      m_cyc = 64'h0;
      m_ins = 64'h0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_clock();
      logic [31:0] v;
      logic        impl;
      logic        ok;
      logic [31:0] old_st;
      mdl_read(csr_idx, v, impl);
      ok = csr_wen && !trap_val && impl && (csr_idx[11:10] != 2'b11);
      old_st = m_reg['h300];
      if (ok && wmask(int'(csr_idx)) != 32'h0)
         m_reg[int'(csr_idx)] = csr_wdat & wmask(int'(csr_idx));
      if (mret_val)
         m_reg['h300] = (32'(old_st[7]) << 3) | 32'h80;
      if (trap_val) begin
         m_reg['h300] = 32'(old_st[3]) << 7;
         m_reg['h341] = trap_pc & 32'hFFFF_FFFE;
         m_reg['h342] = trap_cause;
         m_reg['h343] = trap_tval;
      end
      if (ok && csr_idx == 12'hB00)      m_cyc[31:0]  = csr_wdat;
      else if (ok && csr_idx == 12'hB80) m_cyc[63:32] = csr_wdat;
      else                               m_cyc = m_cyc + 64'd1;
      if (ok && csr_idx == 12'hB02)      m_ins[31:0]  = csr_wdat;
      else if (ok && csr_idx == 12'hB82) m_ins[63:32] = csr_wdat;
      else if (instret)                  m_ins = m_ins + 64'd1;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Compare every output against the model mid-cycle, then take one edge.
   task automatic tick();
      logic [31:0] v;
      logic        impl;
      @(negedge clk);
      mdl_read(csr_idx, v, impl);
      chk("rdat_mdl", csr_rdat, csr_ren ? v : 32'h0);
      chk("ill_mdl", 32'(csr_ill), 32'((csr_ren | csr_wen) & ~impl));
      chk("mtvec_mdl", mtvec_o, m_reg['h305]);
      chk("mepc_mdl", mepc_o, m_reg['h341]);
      chk("irq_mdl", 32'(irq_req), 32'(mdl_irq()));
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic rd_chk(input string name, input logic [11:0] idx, input logic [31:0] exp);
      csr_ren = 1'b1;
      csr_wen = 1'b0;
      csr_idx = idx;
      #1;
      chk(name, csr_rdat, exp);
   endtask

   task automatic wr(input logic [11:0] idx, input logic [31:0] d);
      csr_ren  = 1'b1;
      csr_wen  = 1'b1;
      csr_idx  = idx;
      csr_wdat = d;
      tick();
      csr_wen  = 1'b0;
   endtask

   task automatic clear_inputs();
      csr_ren    = 1'b0;
      csr_wen    = 1'b0;
      csr_idx    = 12'h0;
      csr_wdat   = 32'h0;
      instret    = 1'b0;
      trap_val   = 1'b0;
      trap_cause = 32'h0;
      trap_pc    = 32'h0;
      trap_tval  = 32'h0;
      mret_val   = 1'b0;
      ext_irq    = 1'b0;
      tmr_irq    = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        ren;
      logic        wen;
      logic [11:0] idx;
      logic [31:0] wdat;
      logic [31:0] exp_rdat;
      logic        exp_ill;
   } vec_t;

   vec_t vecs [12];

   logic [11:0] idx_tab [0:19] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                                   12'h341, 12'h342, 12'h343, 12'h344, 12'hB00,
                                   12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12,
                                   12'hF13, 12'hF14, 12'h7C0, 12'hC00, 12'h302};

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 12'h301, 32'h0,         32'h4000_1104, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 12'hF14, 32'h0,         32'h0,         1'b0};
      vecs[2]  = '{1'b1, 1'b0, 12'h300, 32'h0,         32'h0000_1800, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 12'hF11, 32'h0,         32'h0,         1'b0};
      vecs[4]  = '{1'b1, 1'b0, 12'h305, 32'h0,         32'h0,         1'b0};
      vecs[5]  = '{1'b0, 1'b0, 12'h301, 32'h0,         32'h0,         1'b0};
      vecs[6]  = '{1'b1, 1'b0, 12'h7C0, 32'h0,         32'h0,         1'b1};
      vecs[7]  = '{1'b0, 1'b1, 12'h7C0, 32'h1234_5678, 32'h0,         1'b1};
      vecs[8]  = '{1'b0, 1'b0, 12'h7C0, 32'h0,         32'h0,         1'b0};
      vecs[9]  = '{1'b1, 1'b0, 12'hC00, 32'h0,         32'h0,         1'b1};
      vecs[10] = '{1'b1, 1'b0, 12'hF15, 32'h0,         32'h0,         1'b1};
      vecs[11] = '{1'b1, 1'b1, 12'h301, 32'hFFFF_FFFF, 32'h4000_1104, 1'b0};

      clear_inputs();
      rst_n = 1'b0;
      model_reset();

      // Outputs while held in reset.
      #3;
      chk("rst_mtvec", mtvec_o, 32'h0);
      chk("rst_mepc", mepc_o, 32'h0);
      chk("rst_irq", 32'(irq_req), 32'h0);
      rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Table of combinational read/ill checks on constant registers.
      for (int i = 0; i < 12; i++) begin
         csr_ren  = vecs[i].ren;
         csr_wen  = vecs[i].wen;
         csr_idx  = vecs[i].idx;
         csr_wdat = vecs[i].wdat;
         #1;
         chk($sformatf("vec%0d_rdat", i), csr_rdat, vecs[i].exp_rdat);
         chk($sformatf("vec%0d_ill", i), 32'(csr_ill), 32'(vecs[i].exp_ill));
         tick();
      end
      clear_inputs();

      // mtvec low bits forced to zero; visible the cycle after the write.
      wr(12'h305, 32'h8000_0103);
      chk("mtvec_o_wr", mtvec_o, 32'h8000_0100);
      rd_chk("mtvec_rd", 12'h305, 32'h8000_0100);

      // Interrupt enable, trap entry, mret.
      wr(12'h300, 32'h0000_0008);
      wr(12'h304, 32'h0000_0080);
      tmr_irq = 1'b1;
      #1;
      chk("irq_on", 32'(irq_req), 32'h1);
      trap_val   = 1'b1;
      trap_cause = 32'h8000_0007;
      trap_pc    = 32'h0000_1235;
      trap_tval  = 32'h0000_00AB;
      tick();
      trap_val = 1'b0;
      rd_chk("trap_mepc", 12'h341, 32'h0000_1234);
      rd_chk("trap_mstatus", 12'h300, 32'h0000_1880);
      chk("trap_irq_off", 32'(irq_req), 32'h0);
      rd_chk("trap_mcause", 12'h342, 32'h8000_0007);
      tick();
      mret_val = 1'b1;
      tick();
      mret_val = 1'b0;
      rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);
      chk("mret_irq", 32'(irq_req), 32'h1);
      tmr_irq = 1'b0;
      tick();

      // 64-bit carry out of mcycle low half.
      wr(12'hB00, 32'hFFFF_FFFF);
      wr(12'hB80, 32'h0);
      tick();
      rd_chk("mcycleh_carry", 12'hB80, 32'h1);
      rd_chk("mcycle_wrap", 12'hB00, 32'h0);

      // Write to minstret wins over a coincident retire.
      instret = 1'b1;
      wr(12'hB02, 32'h1234_5678);
      instret = 1'b0;
      rd_chk("minstret_wr", 12'hB02, 32'h1234_5678);

      // A trap flushes a same-cycle CSR write.
      wr(12'h340, 32'h1111_2222);
      trap_val   = 1'b1;
      trap_cause = 32'h0000_0002;
      trap_pc    = 32'h0000_0400;
      trap_tval  = 32'h0000_0055;
      wr(12'h340, 32'hDEAD_BEEF);
      trap_val = 1'b0;
      rd_chk("trap_flush_mscratch", 12'h340, 32'h1111_2222);
      rd_chk("trap2_mepc", 12'h341, 32'h0000_0400);
      rd_chk("trap2_mtval", 12'h343, 32'h0000_0055);
      tick();

      // Asynchronous reset in the middle of a cycle with nonzero state.
      wr(12'h304, 32'h0000_0888);
      wr(12'h300, 32'h0000_0008);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_mtvec", mtvec_o, 32'h0);
      chk("arst_mepc", mepc_o, 32'h0);
      chk("arst_irq", 32'(irq_req), 32'h0);
      rd_chk("arst_mscratch", 12'h340, 32'h0);
      rd_chk("arst_mstatus", 12'h300, 32'h0000_1800);
      rd_chk("arst_mcycleh", 12'hB80, 32'h0);
      rd_chk("arst_mie", 12'h304, 32'h0);
      clear_inputs();
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         csr_ren    = ($urandom_range(0, 3) != 0);
         csr_wen    = ($urandom_range(0, 1) == 1);
         csr_idx    = idx_tab[$urandom_range(0, 19)];
         csr_wdat   = $urandom;
         instret    = ($urandom_range(0, 1) == 1);
         trap_val   = ($urandom_range(0, 15) == 0);
         trap_cause = $urandom;
         trap_pc    = $urandom;
         trap_tval  = $urandom;
         mret_val   = ($urandom_range(0, 15) == 0);
         ext_irq    = ($urandom_range(0, 3) == 0);
         tmr_irq    = ($urandom_range(0, 3) == 0);
         tick();
      end
      clear_inputs();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
